full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered binary adder: sums two WIDTH-bit operands and a carry-in, producing a WIDTH-bit sum and a carry-out one clock later.
- Default WIDTH=1 gives the classic single-bit full adder (a, b, cin -> s, cout).
- Used as the arithmetic leaf in datapaths; wider instances form ripple-carry adders from a 1-bit cell.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on rising edge of clk.
- in_valid  input  1  qualifies a, b, cin on this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- out_valid  output  1  s and cout hold a fresh result.
- s  output  WIDTH  registered sum, bits [WIDTH-1:0] of a+b+cin.
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Arithmetic: {cout, s} = a + b + cin, computed at WIDTH+1 bits. No truncation other than that split.
- Per bit i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]); c[0] = cin; cout = c[WIDTH].
- Ripple-carry combinational path through WIDTH cells, then one output register stage.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on s/cout at edge N, and out_valid=1 after it.
- in_valid=0 at an edge: s and cout hold their previous values; out_valid goes to 0.
- out_valid is a registered copy of in_valid. There is no backpressure and no ready signal. Every accepted input produces exactly one result cycle.
- Back-to-back valid inputs give back-to-back results, with full throughput of one per cycle.
- Reset: while rst=1 at an edge, s=0, cout=0, out_valid=0, regardless of in_valid. This also applies mid-stream: a result in flight is discarded.
- First edge with rst=0 and in_valid=1 loads a normal result.
- Wrap-around: all-ones + all-ones + 1 gives s = all-ones, cout=1. All-ones + 0 + 1 gives s=0, cout=1.
- Inputs are never X-propagated intentionally. Behaviour with X inputs is undefined.

Decomposition:
- No shared package types are required. WIDTH is a plain parameter.
- One sub-module, full_adder_cell: purely combinational 1-bit cell with ports a, b, cin, s, cout. It is instantiated WIDTH times in a generate loop with the carry chained.
- Output register, out_valid register and reset logic live in full_adder.

Test Plan:
- WIDTH=1, exhaustive sequence with in_valid=1, applying (a,b,cin) = 000, 010, 110, 100, 101, 001, 011, 111. Required (cout,s) one cycle later: 00, 01, 10, 01, 10, 01, 10, 11.
- Reset: load a=1,b=1,cin=1, then assert rst for one edge -> s=0, cout=0, out_valid=0. Release rst with in_valid=0 -> outputs stay 0.
- Hold: WIDTH=1, valid 1+0+0 (s=1,cout=0), then 3 cycles in_valid=0 with a=b=cin=1 -> s=1, cout=0 held, out_valid=0.
- WIDTH=8 wrap: a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> s=0xFF, cout=1.
- WIDTH=8 throughput: back-to-back valid pairs (0x12+0x34+0 -> 0x46,c0), (0x80+0x80+0 -> 0x00,c1), (0x7F+0x00+1 -> 0x80,c0). Results appear on consecutive cycles with out_valid=1 each cycle.
- WIDTH=16 random: 1000 random a, b, cin with random in_valid. Compare against the reference model {cout,s}=a+b+cin delayed one cycle, checking out_valid alignment.

Source files
------------

// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants for the registered ripple-carry adder.
//   FA_MAX_WIDTH : largest operand width the adder is built for.
// -----------------------------------------------------------------------------
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_if.sv
// -----------------------------------------------------------------------------
// full_adder_if
// Operand and result bundle for full_adder.
//   in_valid : qualifies a, b and cin in the current cycle
//   a, b     : WIDTH-bit unsigned operands
//   cin      : carry into bit 0
//   out_valid: s and cout hold a fresh result
//   s        : registered sum
//   cout     : registered carry out of the top bit
//
// Handshake: valid-only, there is no ready. Every cycle with in_valid=1 at a
// rising clock edge is accepted. Exactly one cycle later out_valid=1 with the
// matching result. No backpressure exists, so the consumer must take each
// result in the cycle it is presented.
// -----------------------------------------------------------------------------
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             cout;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, cin,
    input  out_valid, s, cout
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, s, cout
  );

endinterface : full_adder_if

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Purely combinational 1-bit full adder. It is the leaf of the ripple chain.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit,   a ^ b ^ cin
//   cout : carry out, majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Registered WIDTH-bit ripple-carry adder: {cout, s} = a + b + cin, presented
// one clock after the operands are accepted.
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset; clears s, cout and out_valid
//   bus  : full_adder_if slave modport (in_valid, a, b, cin -> out_valid, s, cout)
// When in_valid=0 the sum and carry registers keep their last result and
// out_valid drops. out_valid is therefore the only indication of a new result.
// -----------------------------------------------------------------------------
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  full_adder_if.slave   bus
);

  // Elaboration-time guard on the supported width range.
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  // carry[i] is the carry into bit i. carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  // Output stage. Reset wins over in_valid, so a result in flight is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s         <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s    <= sum_comb;
        bus.cout <= carry[WIDTH];
      end
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Directed and random checks of full_adder at WIDTH 1, 8 and 16.
// -----------------------------------------------------------------------------
module tb_full_adder;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  full_adder_if #(.WIDTH(1))  if1  ();
  full_adder_if #(.WIDTH(8))  if8  ();
  full_adder_if #(.WIDTH(16)) if16 ();

  full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
  full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  full_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a rising edge. Outputs are sampled 1 ns after
  // the edge that registers them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive1(input logic v, input logic a, input logic b, input logic c);
    if1.in_valid = v; if1.a = a; if1.b = b; if1.cin = c;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    if8.in_valid = v; if8.a = a; if8.b = b; if8.cin = c;
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    if16.in_valid = v; if16.a = a; if16.b = b; if16.cin = c;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // All DUTs are held in reset with in_valid=1 and operands all-ones.
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    drive16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    tick();
    vectors++;
    if ({if1.out_valid, if1.cout, if1.s} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_w1: got {ov,cout,s}=%b want 000", {if1.out_valid, if1.cout, if1.s});
    end
    vectors++;
    if ({if8.out_valid, if8.cout, if8.s} !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_w8: got {ov,cout,s}=%h want 000", {if8.out_valid, if8.cout, if8.s});
    end
    vectors++;
    if ({if16.out_valid, if16.cout, if16.s} !== 18'h00000) begin
      miscompares++;
      $display("FAIL reset_w16: got {ov,cout,s}=%h want 00000", {if16.out_valid, if16.cout, if16.s});
    end

    // Load 1+1+1, then reset with in_valid still high: result discarded.
    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    drive16(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    vectors++;
    if ({if1.out_valid, if1.cout, if1.s} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_load: got {ov,cout,s}=%b want 111", {if1.out_valid, if1.cout, if1.s});
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({if1.out_valid, if1.cout, if1.s} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_midstream: got {ov,cout,s}=%b want 000", {if1.out_valid, if1.cout, if1.s});
    end
    rst = 1'b0;
    drive1(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    vectors++;
    if ({if1.out_valid, if1.cout, if1.s} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release_idle: got {ov,cout,s}=%b want 000", {if1.out_valid, if1.cout, if1.s});
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [2:0] abc_tab [8];
    logic [1:0] exp_tab [8];
    abc_tab = '{3'b000, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b111};
    exp_tab = '{2'b00,  2'b01,  2'b10,  2'b01,  2'b10,  2'b01,  2'b10,  2'b11};
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, abc_tab[i][2], abc_tab[i][1], abc_tab[i][0]);
      tick();
      vectors++;
      if ({if1.out_valid, if1.cout, if1.s} !== {1'b1, exp_tab[i]}) begin
        miscompares++;
        $display("FAIL exhaustive_w1 abc=%b: got {ov,cout,s}=%b want %b",
                 abc_tab[i], {if1.out_valid, if1.cout, if1.s}, {1'b1, exp_tab[i]});
      end
    end
  endtask

  task automatic test_hold_w1();
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({if1.out_valid, if1.cout, if1.s} !== 3'b101) begin
      miscompares++;
      $display("FAIL hold_load: got {ov,cout,s}=%b want 101", {if1.out_valid, if1.cout, if1.s});
    end
    drive1(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({if1.out_valid, if1.cout, if1.s} !== 3'b001) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got {ov,cout,s}=%b want 001", i, {if1.out_valid, if1.cout, if1.s});
      end
    end
  endtask

  task automatic test_wrap_w8();
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    vectors++;
    if ({if8.out_valid, if8.cout, if8.s} !== {1'b1, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL wrap_ff_01_0: got {ov,cout,s}=%h want 300", {if8.out_valid, if8.cout, if8.s});
    end
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    tick();
    vectors++;
    if ({if8.out_valid, if8.cout, if8.s} !== {1'b1, 1'b1, 8'hFF}) begin
      miscompares++;
      $display("FAIL wrap_ff_ff_1: got {ov,cout,s}=%h want 3ff", {if8.out_valid, if8.cout, if8.s});
    end
    drive8(1'b1, 8'hFF, 8'h00, 1'b1);
    tick();
    vectors++;
    if ({if8.out_valid, if8.cout, if8.s} !== {1'b1, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL wrap_ff_00_1: got {ov,cout,s}=%h want 300", {if8.out_valid, if8.cout, if8.s});
    end
  endtask

  task automatic test_back_to_back_w8();
    logic [7:0] a_tab [3];
    logic [7:0] b_tab [3];
    logic       c_tab [3];
    logic [8:0] exp_tab [3];
    a_tab   = '{8'h12, 8'h80, 8'h7F};
    b_tab   = '{8'h34, 8'h80, 8'h00};
    c_tab   = '{1'b0,  1'b0,  1'b1};
    exp_tab = '{9'h046, 9'h100, 9'h080};
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, a_tab[i], b_tab[i], c_tab[i]);
      tick();
      vectors++;
      if ({if8.out_valid, if8.cout, if8.s} !== {1'b1, exp_tab[i]}) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got {ov,cout,s}=%h want %h",
                 i, {if8.out_valid, if8.cout, if8.s}, {1'b1, exp_tab[i]});
      end
    end
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    vectors++;
    if ({if8.out_valid, if8.cout, if8.s} !== {1'b0, 9'h080}) begin
      miscompares++;
      $display("FAIL back_to_back_tail: got {ov,cout,s}=%h want 080", {if8.out_valid, if8.cout, if8.s});
    end
  endtask

  task automatic test_random_w16();
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        v;
    logic [16:0] exp_sum;
    logic        exp_v;
    // Reset state from earlier is 0; the held value follows from there.
    exp_sum = {if16.cout, if16.s};
    if (exp_sum !== 17'h0) begin
      exp_sum = 17'h0;
    end
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      drive16(v, a, b, c);
      if (v) exp_sum = {1'b0, a} + {1'b0, b} + {16'h0, c};
      exp_v = v;
      tick();
      vectors++;
      if ({if16.out_valid, if16.cout, if16.s} !== {exp_v, exp_sum}) begin
        miscompares++;
        $display("FAIL random_w16 #%0d a=%h b=%h cin=%b v=%b: got {ov,cout,s}=%h want %h",
                 i, a, b, c, v, {if16.out_valid, if16.cout, if16.s}, {exp_v, exp_sum});
      end
    end
    drive16(1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    drive16(1'b0, 16'h0000, 16'h0000, 1'b0);
    #1;

    test_reset();
    test_exhaustive_w1();
    test_hold_w1();
    test_wrap_w8();
    test_back_to_back_w8();
    test_random_w16();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_full_adder
